// File: rtl/trace_checker_pkg.sv
// Shared types and arithmetic helpers for the trace checker.
package trace_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int ERR_W = 16;

    function automatic logic [ERR_W-1:0] popcount(input logic [31:0] v);
        logic [ERR_W-1:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + ERR_W'(v[i]);
        end
        return c;
    endfunction

    // Error counter must stick at all-ones rather than wrap.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [ERR_W-1:0] b);
        logic [ERR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ERR_W] ? '1 : s[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/trace_vec_mem.sv
// Expected-vector store: one write port, combinational read; contents are not reset.
// Latency: read is same-cycle. No backpressure. Mask array only with TRACE_CHECKER_MASK_EN.
module trace_vec_mem #(
    parameter  int VW    = 96,
    parameter  int DEPTH = 64,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [VW-1:0] wr_data,
`ifdef TRACE_CHECKER_MASK_EN
    input  logic [VW-1:0] wr_mask,
    output logic [VW-1:0] rd_mask,
`endif
    input  logic [IW-1:0] rd_addr,
    output logic [VW-1:0] rd_data
);

    logic [VW-1:0] data_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = data_q[rd_addr];

`ifdef TRACE_CHECKER_MASK_EN
    logic [VW-1:0] mask_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mask_q[wr_addr] <= wr_mask;
        end
    end

    assign rd_mask = mask_q[rd_addr];
`endif

endmodule

// File: rtl/trace_checker.sv
// Compares observed debug vectors against a loaded expected trace, counting per-channel mismatches.
// Latency: compare result registered one cycle after obs_valid edge. No backpressure; obs_valid gaps stall.
// Optional TRACE_CHECKER_MASK_EN enables per-vector care-bit masks.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 3,
    parameter  int DEPTH = 64,
    parameter  int SKIP  = 2,
    localparam int IW    = $clog2(DEPTH),
    localparam int VW    = NCH * WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [IW-1:0]    load_addr,
    input  logic [VW-1:0]    load_data,
    input  logic [VW-1:0]    load_mask,
    input  logic [IW:0]      num_vectors,
    input  logic             start,
    input  logic             obs_valid,
    input  logic [VW-1:0]    obs_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] error_count,
    output logic [NCH-1:0]   mismatch,
    output logic             fail_valid,
    output logic [IW-1:0]    first_fail_idx,
    output logic [NCH-1:0]   first_fail_ch
);

    localparam int          SW      = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [IW:0] DEPTH_N = (IW + 1)'(DEPTH);

    state_e           state_q, state_d;
    logic [IW:0]      n_q, n_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    skip_q, skip_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [NCH-1:0]   mm_q, mm_d;
    logic             fv_q, fv_d;
    logic [IW-1:0]    ffi_q, ffi_d;
    logic [NCH-1:0]   ffc_q, ffc_d;

    logic [VW-1:0]    rd_data;
    logic [VW-1:0]    cmp_mask;
    logic [NCH-1:0]   mm_now;
    logic             idle_like;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);

    trace_vec_mem #(
        .VW    (VW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (load_en && idle_like),
        .wr_addr (load_addr),
        .wr_data (load_data),
`ifdef TRACE_CHECKER_MASK_EN
        .wr_mask (load_mask),
        .rd_mask (cmp_mask),
`endif
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

`ifndef TRACE_CHECKER_MASK_EN
    logic unused_load_mask;
    assign unused_load_mask = ^load_mask;
    assign cmp_mask         = '1;
`endif

    always_comb begin
        mm_now = '0;
        for (int c = 0; c < NCH; c++) begin
            mm_now[c] = |((obs_data[c*WIDTH +: WIDTH] ^ rd_data[c*WIDTH +: WIDTH])
                          & cmp_mask[c*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        err_d   = err_q;
        mm_d    = mm_q;
        fv_d    = fv_q;
        ffi_d   = ffi_q;
        ffc_d   = ffc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ARM;
                    n_d     = (num_vectors > DEPTH_N) ? DEPTH_N : num_vectors;
                    idx_d   = '0;
                    skip_d  = SW'(SKIP);
                    err_d   = '0;
                    mm_d    = '0;
                    fv_d    = 1'b0;
                    ffi_d   = '0;
                    ffc_d   = '0;
                end
            end
            ARM: begin
                // Leave when the counter reaches zero; SKIP of 0 still spends one cycle here.
                if (skip_q <= SW'(1)) begin
                    state_d = RUN;
                end
                skip_d = (skip_q == '0) ? '0 : skip_q - SW'(1);
            end
            RUN: begin
                if (n_q == '0) begin
                    state_d = DONE;
                end else if (obs_valid) begin
                    mm_d  = mm_now;
                    err_d = sat_add(err_q, popcount(32'(mm_now)));
                    if (!fv_q && (mm_now != '0)) begin
                        fv_d  = 1'b1;
                        ffi_d = idx_q;
                        ffc_d = mm_now;
                    end
                    idx_d = idx_q + IW'(1);
                    if ({1'b0, idx_q} == (n_q - (IW + 1)'(1))) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            skip_q  <= '0;
            err_q   <= '0;
            mm_q    <= '0;
            fv_q    <= 1'b0;
            ffi_q   <= '0;
            ffc_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
            mm_q    <= mm_d;
            fv_q    <= fv_d;
            ffi_q   <= ffi_d;
            ffc_q   <= ffc_d;
        end
    end

    assign busy           = (state_q == ARM) || (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = (state_q == DONE) && (err_q == '0);
    assign error_count    = err_q;
    assign mismatch       = mm_q;
    assign fail_valid     = fv_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_ch  = ffc_q;

endmodule
